// File: rtl/tff_bank_sequencer_pkg.sv
// Purpose: shared command op codes and controller state encoding for the t_ff bank sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tff_seq_pkg;

  // Command op codes. All four 2-bit encodings are legal.
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_COUNT = 2'b10,
    OP_FLIP  = 2'b11
  } op_t;

  // Controller states. The three spare encodings fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_COUNT = 3'd2,
    ST_FLIP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/tff_bank_sequencer_if.sv
// Purpose: command handshake bundle between a requester (master) and the sequencer (slave).
// Latency: n/a (wires only); a transfer happens on cmd_valid & cmd_ready at the rising edge.
// Backpressure: the master holds cmd_op/cmd_arg stable with cmd_valid high until cmd_ready.
// Signals: cmd_valid, cmd_op[1:0] (master->slave); cmd_arg[WIDTH-1:0] (master->slave);
//          cmd_ready (slave->master).
interface tff_bank_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/tff_bank_sequencer_tff.sv
// Purpose: single toggle flip-flop; Q inverts on a clock edge when T is high.
// Latency: 1 cycle from T to Q.
// Backpressure: none.
// Ports: clk, reset (sync, active-high, clears Q), T (toggle enable), Q (state).
module t_ff (
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/tff_bank_sequencer.sv
// Purpose: command-driven controller that generates the T vector for a bank of WIDTH t_ffs.
// Latency: accept -> done is NOP 1, FLIP 2, WRITE k+2 (k mismatched bits), COUNT n+2 cycles.
// Backpressure: cmd_ready only in IDLE and not in reset; commands offered while busy wait.
// Ports: clk, reset (sync, active-high); cmd (slave handshake: valid/ready/op/arg);
//        busy, done (1-cycle pulse), t_vec (T inputs this cycle), q (bank state).
module tff_bank_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tff_bank_sequencer_if.slave  cmd,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     t_vec,
  output logic [WIDTH-1:0]     q
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] mism;
  logic [WIDTH-1:0] mism_low;
  logic [WIDTH-1:0] inc_tvec;
  logic [WIDTH-1:0] t_vec_raw;

  // Bits still differing from the WRITE target; only the lowest one toggles per cycle.
  assign mism     = q ^ target_q;
  assign mism_low = mism & (~mism + 1'b1);

  // +1 toggle pattern: bit i flips when every lower bit is one (ripple carry).
  always_comb begin
    inc_tvec    = '0;
    inc_tvec[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_tvec[i] = inc_tvec[i-1] & q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rem_q    <= rem_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    rem_d         = rem_q;
    t_vec_raw     = '0;
    done          = 1'b0;
    cmd.cmd_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd.cmd_ready = ~reset;
        if (cmd.cmd_valid && !reset) begin
          case (op_t'(cmd.cmd_op))
            OP_WRITE: begin
              target_d = cmd.cmd_arg;
              state_d  = ST_WRITE;
            end
            OP_COUNT: begin
              rem_d   = cmd.cmd_arg;
              state_d = ST_COUNT;
            end
            OP_FLIP:  state_d = ST_FLIP;
            default:  state_d = ST_DONE;
          endcase
        end
      end
      ST_WRITE: begin
        if (mism != '0) begin
          t_vec_raw = mism_low;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_COUNT: begin
        if (rem_q != '0) begin
          t_vec_raw = inc_tvec;
          rem_d     = rem_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FLIP: begin
        t_vec_raw = '1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = ~reset;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // While reset is held the bank clears regardless of T, so report a quiet controller.
  assign t_vec = reset ? '0 : t_vec_raw;
  assign busy  = (state_q != ST_IDLE) && !reset;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    t_ff u_tff (
      .clk   (clk),
      .reset (reset),
      .T     (t_vec[i]),
      .Q     (q[i])
    );
  end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
module tb_tff_bank_sequencer;
  import tff_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy, done;
  logic [3:0] t_vec, q;
  logic [3:0] mq;        // reference bank value
  int         vectors = 0;
  int         miscompares = 0;

  tff_bank_sequencer_if #(.WIDTH(4)) bus ();

  tff_bank_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (bus),
    .busy  (busy),
    .done  (done),
    .t_vec (t_vec),
    .q     (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] lowest_bit(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) return 4'(1 << i);
    end
    return 4'h0;
  endfunction

  // Issue one command starting at a negedge and follow it cycle by cycle to the IDLE after done.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg);
    logic [3:0] exp_t[$];
    logic [3:0] exp_q[$];
    logic [3:0] cur, nxt, b;
    int guard;
    cur = mq;
    case (op)
      OP_WRITE: begin
        while (cur != arg) begin
          b = lowest_bit(cur ^ arg);
          exp_t.push_back(b); exp_q.push_back(cur);
          cur = cur ^ b;
        end
        exp_t.push_back(4'h0); exp_q.push_back(cur);
      end
      OP_COUNT: begin
        for (int n = 0; n < int'(arg); n++) begin
          nxt = cur + 4'd1;
          exp_t.push_back(cur ^ nxt); exp_q.push_back(cur);
          cur = nxt;
        end
        exp_t.push_back(4'h0); exp_q.push_back(cur);
      end
      OP_FLIP: begin
        exp_t.push_back(4'hF); exp_q.push_back(cur);
        cur = ~cur;
      end
      default: ;
    endcase
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg;
    #1;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_arg = 4'h0;
    foreach (exp_t[i]) begin
      @(negedge clk);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_tvec", 32'(t_vec), 32'(exp_t[i]));
      chk("run_q",    32'(q),     32'(exp_q[i]));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_ready", 32'(bus.cmd_ready), 32'd0);
    chk("done_tvec",  32'(t_vec), 32'd0);
    chk("done_q",     32'(q), 32'(cur));
    @(negedge clk);
    chk("idle_done",  32'(done), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_q",     32'(q), 32'(cur));
    mq = cur;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_arg = 4'h0;
    mq = 4'h0;

    // Reset held for two edges.
    @(negedge clk); @(negedge clk);
    chk("rst_q",     32'(q), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    // WRITE 1010 from 0000: toggles 0010 then 1000, three WRITE cycles.
    run_cmd(OP_WRITE, 4'b1010);
    chk("t2_q", 32'(q), 32'b1010);

    // COUNT 3 from 1110 wraps through 1111, 0000 to 0001.
    run_cmd(OP_WRITE, 4'b1110);
    run_cmd(OP_COUNT, 4'd3);
    chk("t3_q", 32'(q), 32'b0001);

    // FLIP from 0001, then COUNT 0 leaves the bank alone.
    run_cmd(OP_FLIP, 4'h0);
    chk("t4_flip_q", 32'(q), 32'b1110);
    run_cmd(OP_COUNT, 4'd0);
    chk("t4_count0_q", 32'(q), 32'b1110);

    // Reset during the second WRITE cycle aborts without a done pulse.
    run_cmd(OP_WRITE, 4'b0000);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE; bus.cmd_arg = 4'b1111;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_c1_tvec", 32'(t_vec), 32'b0001);
    @(negedge clk);
    chk("t5_c2_q", 32'(q), 32'b0001);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_q",     32'(q), 32'd0);
    chk("t5_rst_done",  32'(done), 32'd0);
    chk("t5_rst_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy",  32'(busy), 32'd0);
    chk("t5_idle_done",  32'(done), 32'd0);
    chk("t5_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t5_idle_q",     32'(q), 32'd0);
    mq = 4'h0;

    // NOP held valid behind a FLIP: waits for ready, then gives its own done.
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_FLIP; bus.cmd_arg = 4'h0;
    @(posedge clk); #1;
    bus.cmd_op = OP_NOP;
    @(negedge clk);
    chk("t6_flip_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t6_flip_tvec",  32'(t_vec), 32'hF);
    @(negedge clk);
    chk("t6_done1",      32'(done), 32'd1);
    chk("t6_done1_rdy",  32'(bus.cmd_ready), 32'd0);
    chk("t6_done1_q",    32'(q), 32'hF);
    @(negedge clk);
    chk("t6_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t6_idle_done",  32'(done), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t6_done2",      32'(done), 32'd1);
    chk("t6_done2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t6_end_done",   32'(done), 32'd0);
    chk("t6_end_q",      32'(q), 32'hF);
    mq = 4'hF;

    // Random back-to-back commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
